// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - PLL-qualified clock-enable and ordered per-stage reset release/assert sequencer
module reset_sequencer #(
  parameter int N_STAGES    = 3,
  parameter int LOCK_CYCLES = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                pll_locked,
  input  logic                run_req,
  input  logic [N_STAGES-1:0] stage_ack,
  output logic                clk_en,
  output logic [N_STAGES-1:0] stage_rst_n,
  output logic                ready,
  output logic                fault
);

  localparam int LC_W  = $clog2(LOCK_CYCLES);
  localparam int WC_W  = $clog2(ACK_TIMEOUT + 1);
  localparam int IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  localparam logic [LC_W-1:0]  LOCK_LAST = LC_W'(LOCK_CYCLES - 1);
  localparam logic [WC_W-1:0]  WAIT_LAST = WC_W'(ACK_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_STAGES - 1);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_LOCK_WAIT,
    ST_RELEASE,
    ST_RUN,
    ST_SHUTDOWN,
    ST_FAULT
  } state_t;

  state_t              state_q;
  logic [1:0]          sync_q;
  logic [LC_W-1:0]     lock_cnt_q;
  logic [WC_W-1:0]     wait_cnt_q;
  logic [IDX_W-1:0]    idx_q;
  logic                clk_en_q;
  logic [N_STAGES-1:0] stage_rst_n_q;
  logic                ready_q;
  logic                fault_q;

  logic                lock_s;
  logic                lock_lost;
  logic [IDX_W-1:0]    idx_inc;

  assign lock_s  = sync_q[1];
  assign idx_inc = (idx_q == IDX_LAST) ? idx_q : idx_q + IDX_W'(1);

  // Lock loss overrides everything once the clock has been opened, except FAULT
  assign lock_lost = !lock_s &&
                     (state_q == ST_RELEASE || state_q == ST_RUN || state_q == ST_SHUTDOWN);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], pll_locked};
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q       <= ST_OFF;
      lock_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      idx_q         <= '0;
      clk_en_q      <= 1'b0;
      stage_rst_n_q <= '0;
      ready_q       <= 1'b0;
      fault_q       <= 1'b0;
    end else if (lock_lost) begin
      state_q       <= ST_OFF;
      lock_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      idx_q         <= '0;
      clk_en_q      <= 1'b0;
      stage_rst_n_q <= '0;
      ready_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_OFF: begin
          clk_en_q      <= 1'b0;
          stage_rst_n_q <= '0;
          ready_q       <= 1'b0;
          fault_q       <= 1'b0;
          if (run_req && lock_s) begin
            state_q    <= ST_LOCK_WAIT;
            lock_cnt_q <= '0;
          end
        end

        ST_LOCK_WAIT: begin
          if (!run_req) begin
            state_q <= ST_OFF;
          end else if (!lock_s) begin
            lock_cnt_q <= '0;
          end else if (lock_cnt_q == LOCK_LAST) begin
            state_q    <= ST_RELEASE;
            clk_en_q   <= 1'b1;
            idx_q      <= '0;
            wait_cnt_q <= '0;
          end else begin
            lock_cnt_q <= lock_cnt_q + LC_W'(1);
          end
        end

        // Acks are only sampled once the stage's reset has actually been released
        ST_RELEASE: begin
          if (!stage_rst_n_q[idx_q]) begin
            stage_rst_n_q[idx_q] <= 1'b1;
          end else if (stage_ack[idx_q]) begin
            if (idx_q == IDX_LAST) begin
              state_q <= ST_RUN;
              ready_q <= 1'b1;
            end else begin
              stage_rst_n_q[idx_inc] <= 1'b1;
              idx_q                  <= idx_inc;
              wait_cnt_q             <= '0;
            end
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_q       <= ST_FAULT;
            fault_q       <= 1'b1;
            clk_en_q      <= 1'b0;
            stage_rst_n_q <= '0;
            wait_cnt_q    <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q + WC_W'(1);
          end
        end

        ST_RUN: begin
          if (!run_req) begin
            state_q <= ST_SHUTDOWN;
            ready_q <= 1'b0;
            idx_q   <= IDX_LAST;
          end
        end

        ST_SHUTDOWN: begin
          if (stage_rst_n_q == '0) begin
            state_q  <= ST_OFF;
            clk_en_q <= 1'b0;
          end else begin
            stage_rst_n_q[idx_q] <= 1'b0;
            if (idx_q != '0) begin
              idx_q <= idx_q - IDX_W'(1);
            end
          end
        end

        ST_FAULT: begin
          if (!run_req) begin
            state_q <= ST_OFF;
            fault_q <= 1'b0;
          end
        end

        default: begin
          state_q <= ST_OFF;
        end
      endcase
    end
  end

  assign clk_en      = clk_en_q;
  assign stage_rst_n = stage_rst_n_q;
  assign ready       = ready_q;
  assign fault       = fault_q;

endmodule
